// File: rtl/main.sv
// IDEA block cipher core: captures a 64-bit block and a 128-bit key, runs one round
// per cycle, and presents the result 10 cycles after capture (encrypt or decrypt).
module main (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:63]  text,
  input  logic [0:127] key,
  input  logic         action,
  output logic [0:63]  encryptedText
);

  typedef enum logic [1:0] {LOAD, ROUND, OUT} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [63:0]  x_p0;
  logic [127:0] key_p0;
  logic         act_p0;
  logic [63:0]  res_p1;
  logic         vld_p1;

  logic [127:0] rk;
  logic [15:0]  z0 [0:51];
  logic [2:0]   r0;
  logic [5:0]   b6;
  logic [15:0]  inv_a_in, inv_b_in, inv_a, inv_b;
  logic [15:0]  k1, k2, k3, k4, k5, k6;
  logic [63:0]  round_out, final_out;

  // Multiplication mod 2^16+1 where a 16-bit zero stands for 2^16.
  function automatic logic [15:0] mul_mod(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] lo, hi;
    if (a == 16'd0) begin
      mul_mod = 16'd1 - b;
    end else if (b == 16'd0) begin
      mul_mod = 16'd1 - a;
    end else begin
      p = 32'(a) * 32'(b);
      lo = p[15:0];
      hi = p[31:16];
      mul_mod = lo - hi + {15'd0, (lo < hi)};
    end
  endfunction

  // Inverse via x^(p-2) with p = 65537; exponent 0xFFFF is the product of x^(2^i), i=0..15.
  function automatic logic [15:0] mul_inv(input logic [15:0] x);
    logic [15:0] p, acc;
    p = x;
    acc = x;
    for (int i = 1; i < 16; i++) begin
      p = mul_mod(p, p);
      acc = mul_mod(acc, p);
    end
    mul_inv = acc;
  endfunction

  function automatic logic [15:0] add_inv(input logic [15:0] x);
    add_inv = 16'd0 - x;
  endfunction

  function automatic logic [63:0] idea_round(input logic [63:0] x,
                                             input logic [15:0] c1, input logic [15:0] c2,
                                             input logic [15:0] c3, input logic [15:0] c4,
                                             input logic [15:0] c5, input logic [15:0] c6);
    logic [15:0] a, b, c, d, e, f, g;
    a = mul_mod(x[63:48], c1);
    b = x[47:32] + c2;
    c = x[31:16] + c3;
    d = mul_mod(x[15:0], c4);
    e = mul_mod(a ^ c, c5);
    f = mul_mod((b ^ d) + e, c6);
    g = e + f;
    idea_round = {a ^ f, c ^ f, b ^ g, d ^ g};
  endfunction

  // Output transform undoes the middle-word swap of the last round.
  function automatic logic [63:0] idea_out(input logic [63:0] x,
                                           input logic [15:0] c1, input logic [15:0] c2,
                                           input logic [15:0] c3, input logic [15:0] c4);
    idea_out = {mul_mod(x[63:48], c1), x[31:16] + c2, x[47:32] + c3, mul_mod(x[15:0], c4)};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = ROUND;
      ROUND:   if (cnt == 4'd8) state_nxt = OUT;
      OUT:     state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Key schedule: 52 words, rotating the key left by 25 after every 8 words.
  always_comb begin
    rk = key_p0;
    for (int i = 0; i < 52; i++) begin
      z0[i] = rk[127 - 16 * (i % 8) -: 16];
      if ((i % 8) == 7) rk = {rk[102:0], rk[127:103]};
    end
  end

  assign r0 = cnt[2:0] - 3'd1;
  assign b6 = {3'b000, r0} * 6'd6;

  always_comb begin
    if (state == OUT) begin
      inv_a_in = z0[0];
      inv_b_in = z0[3];
    end else begin
      inv_a_in = z0[6'd48 - b6];
      inv_b_in = z0[6'd51 - b6];
    end
  end

  assign inv_a = mul_inv(inv_a_in);
  assign inv_b = mul_inv(inv_b_in);

  always_comb begin
    k1 = 16'd0; k2 = 16'd0; k3 = 16'd0;
    k4 = 16'd0; k5 = 16'd0; k6 = 16'd0;
    if (act_p0) begin
      if (state == OUT) begin
        k1 = z0[48]; k2 = z0[49]; k3 = z0[50]; k4 = z0[51];
      end else begin
        k1 = z0[b6];          k2 = z0[b6 + 6'd1]; k3 = z0[b6 + 6'd2];
        k4 = z0[b6 + 6'd3];   k5 = z0[b6 + 6'd4]; k6 = z0[b6 + 6'd5];
      end
    end else begin
      if (state == OUT) begin
        k1 = inv_a; k2 = add_inv(z0[1]); k3 = add_inv(z0[2]); k4 = inv_b;
      end else begin
        k1 = inv_a;
        k4 = inv_b;
        k5 = z0[6'd46 - b6];
        k6 = z0[6'd47 - b6];
        // First decrypt round takes its additive keys in the opposite order.
        k2 = add_inv((r0 == 3'd0) ? z0[49] : z0[6'd50 - b6]);
        k3 = add_inv((r0 == 3'd0) ? z0[50] : z0[6'd49 - b6]);
      end
    end
  end

  assign round_out = idea_round(x_p0, k1, k2, k3, k4, k5, k6);
  assign final_out = idea_out(x_p0, k1, k2, k3, k4);

  // p0: capture and round iteration; p1: transformed result; output register on next LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= 4'd0;
      x_p0          <= 64'd0;
      key_p0        <= 128'd0;
      act_p0        <= 1'b0;
      res_p1        <= 64'd0;
      vld_p1        <= 1'b0;
      encryptedText <= 64'd0;
    end else begin
      case (state)
        LOAD: begin
          x_p0   <= text;
          key_p0 <= key;
          act_p0 <= action;
          cnt    <= 4'd1;
          vld_p1 <= 1'b0;
          if (vld_p1) encryptedText <= res_p1;
        end
        ROUND: begin
          x_p0 <= round_out;
          cnt  <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
        end
        OUT: begin
          res_p1 <= final_out;
          vld_p1 <= 1'b1;
          cnt    <= 4'd0;
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_main.sv
// Scoreboard bench for the IDEA core: expected blocks queued at capture,
// compared when the result lands 10 edges later.
module tb_main;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         action = 1'b0;
  logic [0:63]  text = '0;
  logic [0:127] key = '0;
  logic [0:63]  encryptedText;

  main dut (
    .clk(clk),
    .reset(reset),
    .text(text),
    .key(key),
    .action(action),
    .encryptedText(encryptedText)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] last_exp = 64'd0;
  bit          primed = 1'b0;

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    longint aa, bb, r;
    aa = (a == 16'd0) ? 65536 : longint'(a);
    bb = (b == 16'd0) ? 65536 : longint'(b);
    r = (aa * bb) % 65537;
    m_mul = (r == 65536) ? 16'd0 : 16'(r);
  endfunction

  function automatic logic [15:0] m_inv(input logic [15:0] x);
    int t0, t1, r0, r1, q, tmp;
    if (x == 16'd0) return 16'd0;
    t0 = 0; t1 = 1; r0 = 65537; r1 = int'(x);
    while (r1 != 0) begin
      q = r0 / r1;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
    end
    if (t0 < 0) t0 += 65537;
    m_inv = 16'(t0);
  endfunction

  function automatic logic [63:0] idea_model(input logic [127:0] k, input logic [63:0] t,
                                             input logic enc);
    logic [127:0] kk;
    logic [15:0]  z [1:52];
    logic [15:0]  sk [1:52];
    logic [15:0]  x1, x2, x3, x4, a, b, c, d, e, f, g;
    int           base;
    kk = k;
    for (int i = 0; i < 52; i++) begin
      z[i + 1] = kk[127 - 16 * (i % 8) -: 16];
      if ((i % 8) == 7) kk = {kk[102:0], kk[127:103]};
    end
    if (enc) begin
      for (int i = 1; i <= 52; i++) sk[i] = z[i];
    end else begin
      for (int r = 1; r <= 8; r++) begin
        sk[6*r-5] = m_inv(z[55-6*r]);
        sk[6*r-2] = m_inv(z[58-6*r]);
        sk[6*r-1] = z[53-6*r];
        sk[6*r]   = z[54-6*r];
        sk[6*r-4] = 16'h0 - ((r == 1) ? z[50] : z[57-6*r]);
        sk[6*r-3] = 16'h0 - ((r == 1) ? z[51] : z[56-6*r]);
      end
      sk[49] = m_inv(z[1]);
      sk[50] = 16'h0 - z[2];
      sk[51] = 16'h0 - z[3];
      sk[52] = m_inv(z[4]);
    end
    x1 = t[63:48]; x2 = t[47:32]; x3 = t[31:16]; x4 = t[15:0];
    for (int r = 1; r <= 8; r++) begin
      base = 6 * r - 6;
      a = m_mul(x1, sk[base+1]);
      b = x2 + sk[base+2];
      c = x3 + sk[base+3];
      d = m_mul(x4, sk[base+4]);
      e = m_mul(a ^ c, sk[base+5]);
      f = m_mul(16'((b ^ d) + e), sk[base+6]);
      g = e + f;
      x1 = a ^ f; x2 = c ^ f; x3 = b ^ g; x4 = d ^ g;
    end
    idea_model = {m_mul(x1, sk[49]), 16'(x3 + sk[50]), 16'(x2 + sk[51]), m_mul(x4, sk[52])};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [127:0] k, input logic [63:0] t, input logic a);
    key = k;
    text = t;
    action = a;
  endtask

  task automatic push(input logic [63:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Capture edge; it is also the edge where the previous operation's result appears.
  task automatic step_capture();
    string tg;
    @(posedge clk); #1;
    if (primed) begin
      if (exp_q.size() > 0) begin
        last_exp = exp_q.pop_front();
        tg = tag_q.pop_front();
        check(tg, encryptedText, last_exp);
      end else begin
        check("sb_underflow", 64'(exp_q.size()), 64'd1);
      end
    end
    primed = 1'b1;
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check("hold", encryptedText, last_exp);
    end
  endtask

  task automatic op(input logic [127:0] k, input logic [63:0] t, input logic a,
                    input logic [63:0] e, input string tag);
    apply(k, t, a);
    push(e, tag);
    step_capture();
    hold(9);
  endtask

  localparam logic [127:0] KV = 128'h9d4075c103bc322afb03e7be6ab30006;
  localparam logic [63:0]  PV = 64'hf5db1ac45e5ef9f9;
  localparam logic [63:0]  CV = 64'h53bff7278ac667db;

  initial begin
    logic [127:0] rk;
    logic [63:0]  rt, rc;

    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset", encryptedText, 64'd0);
    end
    reset = 1'b0;
    primed = 1'b0;
    last_exp = 64'd0;

    op(KV, PV, 1'b1, CV, "vec_enc");
    op(KV, CV, 1'b0, PV, "vec_dec");

    // Inputs switched mid-ROUND only affect the following operation.
    apply(KV, PV, 1'b1);
    push(CV, "mid_enc");
    step_capture();
    hold(4);
    apply(KV, CV, 1'b0);
    hold(5);
    push(PV, "mid_dec");
    step_capture();
    hold(9);

    // Reset mid-ROUND aborts the running operation.
    apply(KV, PV, 1'b1);
    push(CV, "aborted");
    step_capture();
    hold(4);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_mid", encryptedText, 64'd0);
    end
    reset = 1'b0;
    exp_q.delete();
    tag_q.delete();
    primed = 1'b0;
    last_exp = 64'd0;

    rc = idea_model(128'd0, 64'd0, 1'b1);
    op(128'd0, 64'd0, 1'b1, rc, "zero_enc");
    op(128'd0, rc, 1'b0, 64'd0, "zero_dec");

    for (int i = 0; i < 6; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rt = {$urandom, $urandom};
      rc = idea_model(rk, rt, 1'b1);
      op(rk, rt, 1'b1, rc, "rnd_enc");
      op(rk, rc, 1'b0, rt, "rnd_dec");
    end
    rk = {$urandom, $urandom, $urandom, $urandom};
    rt = {$urandom, $urandom};
    op(rk, rt, 1'b0, idea_model(rk, rt, 1'b0), "rnd_dec_only");

    step_capture();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
